// File: rtl/rr_dec16_arbiter.sv
// rtl/rr_dec16_arbiter.sv - round-robin arbiter driving a 4-to-16 decoder select
//
// Purpose: shares one decoded 16-way one-hot select among 16 requesters.
// One requester is granted at a time. A grant lasts at most MAX_HOLD cycles.
// After every grant there is one idle cycle. In that idle cycle the next
// winner is picked in rotating order.
//
// Ports:
//   clk  in   1   system clock, rising edge
//   rst  in   1   synchronous active-high reset
//   e    in   1   enable; 0 blocks new grants and ends the current one
//   req  in  16   request vector, bit i = requester i
//   idx  out  4   index of current grantee (decoder select)
//   gv   out  1   grant valid (decoder enable)
//   gnt  out 16   one-hot grant, 1<<idx when gv else 0
module rr_dec16_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        e,
    input  logic [15:0] req,
    output logic [3:0]  idx,
    output logic        gv,
    output logic [15:0] gnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        win_found;
    logic [3:0]  win_idx;
    logic [3:0]  pos;

    // Search for the first set request bit, starting at ptr_q.
    // The position wraps modulo 16 through the natural 4-bit overflow.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        pos       = ptr_q;
        for (int k = 0; k < 16; k++) begin
            pos = ptr_q + 4'(k);
            if (!win_found && req[pos]) begin
                win_found = 1'b1;
                win_idx   = pos;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (e && win_found) begin
                    state_d = ST_GRANT;
                    idx_d   = win_idx;
                    cnt_d   = 4'd0;
                end
            end
            ST_GRANT: begin
                // The release conditions overlap freely. Any combination
                // of them gives a single release, and the pointer moves
                // just past the grantee.
                if (!e || !req[idx_q] || (cnt_q == HOLD_LAST)) begin
                    state_d = ST_IDLE;
                    ptr_d   = idx_q + 4'd1;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            ptr_q   <= 4'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are taken from registers only, so there is no path from req or e.
    assign gv  = (state_q == ST_GRANT);
    assign idx = idx_q;
    assign gnt = gv ? (16'h0001 << idx_q) : 16'h0000;

endmodule

// File: tb/tb_rr_dec16_arbiter.sv
// tb/tb_rr_dec16_arbiter.sv - scoreboard bench for rr_dec16_arbiter
module tb_rr_dec16_arbiter;

    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        e;
    logic [15:0] req;
    logic [3:0]  idx;
    logic        gv;
    logic [15:0] gnt;

    rr_dec16_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .e   (e),
        .req (req),
        .idx (idx),
        .gv  (gv),
        .gnt (gnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        gv;
        logic [3:0]  idx;
        logic [15:0] gnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: the grant state, the grantee, the search start
    // and the number of cycles the current grant has lasted so far.
    bit m_busy = 0;
    int m_idx  = 0;
    int m_ptr  = 0;
    int m_held = 0;

    function automatic void model_step(bit r, bit en, logic [15:0] rq);
        if (r) begin
            m_busy = 0; m_idx = 0; m_ptr = 0; m_held = 0;
        end else if (!m_busy) begin
            if (en && rq != 16'h0) begin
                for (int d = 0; d < 16; d++) begin
                    if (rq[(m_ptr + d) % 16]) begin
                        m_idx = (m_ptr + d) % 16;
                        break;
                    end
                end
                m_busy = 1;
                m_held = 1;
            end
        end else begin
            if (!en || !rq[m_idx] || m_held == MAX_HOLD) begin
                m_busy = 0;
                m_ptr  = (m_idx + 1) % 16;
            end else begin
                m_held = m_held + 1;
            end
        end
    endfunction

    // Apply one cycle of inputs. The expected outputs after the next edge
    // are pushed to the queue.
    task automatic cycle(input bit r, input bit en, input logic [15:0] rq);
        exp_t x;
        rst = r; e = en; req = rq;
        model_step(r, en, rq);
        x.gv  = m_busy;
        x.idx = 4'(m_idx);
        x.gnt = m_busy ? (16'h0001 << m_idx) : 16'h0000;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n, input bit r, input bit en, input logic [15:0] rq);
        for (int i = 0; i < n; i++) cycle(r, en, rq);
    endtask

    // Monitor: the DUT presents a result every cycle. Each one is checked
    // against the oldest expected entry.
    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            cyc++;
            total++;
            if (gv !== x.gv) begin
                bad++;
                $display("FAIL gv cyc=%0d got=%0b want=%0b", cyc, gv, x.gv);
            end
            total++;
            if (gnt !== x.gnt) begin
                bad++;
                $display("FAIL gnt cyc=%0d got=%h want=%h", cyc, gnt, x.gnt);
            end
            total++;
            if (idx !== x.idx) begin
                bad++;
                $display("FAIL idx cyc=%0d got=%0d want=%0d", cyc, idx, x.idx);
            end
        end
    end

    initial begin
        logic [15:0] rq;
        bit          en;
        // 1: reset with everything requesting, then the first grant goes to 0
        cycles(2, 1, 1, 16'hFFFF);
        cycles(6, 0, 1, 16'hFFFF);
        // 2: single continuous requester
        cycle(1, 1, 16'h0000);
        cycles(12, 0, 1, 16'h0010);
        // 3: 15->0 wrap
        cycle(1, 1, 16'h0000);
        cycles(16, 0, 1, 16'h8001);
        // 4: early release of bit 2 after two grant cycles
        cycle(1, 1, 16'h0000);
        cycles(2, 0, 1, 16'h0104);
        cycles(6, 0, 1, 16'h0100);
        // 5: enable drop during grant of idx 5
        cycle(1, 1, 16'h0000);
        cycles(2, 0, 1, 16'h0020);
        cycles(5, 0, 0, 16'hFFFF);
        cycles(6, 0, 1, 16'hFFFF);
        // 6: reset during the third cycle of a grant of idx 9
        cycle(1, 1, 16'h0000);
        cycles(3, 0, 1, 16'h0200);
        cycle(1, 1, 16'hFFFF);
        cycles(4, 0, 1, 16'hFFFF);
        // all requesting continuously: full rotation
        cycles(90, 0, 1, 16'hFFFF);
        // randomized traffic
        rq = 16'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: rq = 16'h0;
                    1: rq = 16'h0001 << $urandom_range(0, 15);
                    2: rq = 16'($urandom) & 16'($urandom);
                    default: rq = 16'($urandom);
                endcase
            end
            en = ($urandom_range(0, 7) != 0);
            cycle($urandom_range(0, 99) == 0, en, rq);
        end
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_dec16_arbiter.md
Name: rr_dec16_arbiter

Overview:
- Round-robin arbiter that shares one 16-way one-hot select resource, the 4-to-16 decoder output, among 16 requesters.
- Picks one requester, holds the grant for a bounded number of cycles, then rotates priority.
- Drives the 4-bit index plus enable that feed the decoder, and also exposes the decoded one-hot grant.
- Sits between the request sources and the decoded select lines.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one grant may last; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
e  input  1  arbiter enable; 0 blocks new grants and terminates the current grant
req  input  16  request vector; bit i = requester i wants the resource
idx  output  4  index of the current grantee (decoder select input)
gv  output  1  grant valid (decoder enable input)
gnt  output  16  one-hot grant; equals 1<<idx when gv=1, else 16'h0000

Behaviour:
- Reset (rst=1 at a rising edge):
  - state<=IDLE, idx<=0, ptr<=0, cnt<=0.
  - Outputs next cycle: gv=0, gnt=16'h0000, idx=4'h0.
  - Reset dominates all other inputs and aborts any grant in progress.
- Registers: state (IDLE/GRANT), idx[3:0], ptr[3:0] (highest-priority position), cnt[3:0] (hold counter).
- Output decode:
  - gv = (state==GRANT).
  - gnt = gv ? one-hot decode of idx : 0.
  - Outputs depend only on registers. No combinational path from req or e to any output.
- IDLE:
  - If e=1 and req!=0: winner = first set bit of req scanning ptr, ptr+1, ... mod 16 (15 wraps to 0). Then state<=GRANT, idx<=winner, cnt<=0.
  - Otherwise stay in IDLE; idx, ptr and cnt hold.
  - Latency: request sampled in cycle n gives gv=1 in cycle n+1.
- GRANT: release when any of e=0, req[idx]=0, or cnt==MAX_HOLD-1.
  - On release: state<=IDLE, ptr<=idx+1 (mod 16), cnt<=0. idx holds its value; gnt and gv go to 0.
  - Otherwise: cnt<=cnt+1.
  - A grant therefore lasts at most MAX_HOLD cycles and at least 1 cycle.
- Turnaround: after every grant there is exactly one IDLE cycle with gv=0 before the next grant, even when requests are pending. Arbitration happens in that IDLE cycle.
- Fairness: the requester just served has the lowest priority next round. With all 16 requesting continuously, grants go 0,1,...,15,0,...
- Simultaneous events:
  - A request bit that rises during another's grant is considered only at the next IDLE cycle.
  - Changes to req bits other than req[idx] have no effect during GRANT.
  - e=0 and hold expiry in the same cycle: single release, ptr<=idx+1.
- e=0 in IDLE: no grant, ptr unchanged.
- X-safety: no grant is issued when req=0. idx is don't-care when gv=0, but must hold its last value.

Test Plan:
1. Reset behaviour: rst=1 for 2 cycles with req=16'hFFFF, e=1 -> gv=0, gnt=16'h0000 throughout. First grant after release of rst is gnt=16'h0001, idx=0.
2. Single continuous requester: req=16'h0010, e=1 held, MAX_HOLD=4 -> pattern repeats.
   - gnt=16'h0010, idx=4 for 4 cycles.
   - 1 cycle of gnt=0.
   - 4 cycles of 16'h0010 again.
3. Round-robin wrap: req=16'h8001 held -> grant sequence 16'h0001 (4 cycles), gap, 16'h8000 (4 cycles), gap, 16'h0001, confirming the 15->0 wrap of ptr.
4. Early release: req=16'h0104, bit 2 dropped after its 2nd grant cycle -> gnt=16'h0004 for exactly 2 cycles, 1 gap cycle, then gnt=16'h0100 (ptr was 3, so bit 8 wins).
5. Enable control: e dropped to 0 during a grant of idx=5 -> gv=0 next cycle, ptr=6. While e=0, no grants appear with req=16'hFFFF. After e returns to 1, the first grant is idx=6.
6. Reset mid-grant: rst=1 during cnt=2 of a grant of idx=9 -> gv=0 next cycle, ptr=0. With req=16'hFFFF, the next grant is idx=0, not idx=10.
